alu2_action_issuer: RTL

- Initiator side of the type-2 ALU (load/store) action interface in an RMT action stage.
- Accepts one PHV (NUM_CONT 32-bit containers) with its 25-bit action word.
- Decodes the action, selects operands from the PHV, issues one single-cycle action_valid pulse to the ALU, then waits for the ALU result.
- Writes the result back into the destination container and presents the updated PHV downstream with a valid/ready handshake.

---
 rtl/rmt_action_pkg.sv | 30 +++
 rtl/alu2_operand_sel.sv | 75 +++++++
 rtl/alu2_action_issuer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rmt_action_pkg.sv
// Shared definitions for the RMT action-stage ALU interfaces: opcodes, action
// word field positions and the issuer FSM encoding.
package rmt_action_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1011;

    localparam int OP_MSB   = 24;
    localparam int OP_LSB   = 21;
    localparam int IDX1_MSB = 20;
    localparam int IDX1_LSB = 16;
    localparam int IDX2_MSB = 15;
    localparam int IDX2_LSB = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int ADDR_MSB = 4;
    localparam int ADDR_LSB = 0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StWait   = 2'd2,
        StOutput = 2'd3
    } issuer_state_e;

endpackage

// File: rtl/alu2_operand_sel.sv
// Combinational action decode: picks ALU operands out of the PHV and flags
// actions that reference a container index outside the PHV.
module alu2_operand_sel
    import rmt_action_pkg::*;
#(
    parameter int unsigned NUM_CONT   = 8,
    parameter int unsigned ACTION_LEN = 25,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv,
    input  logic [ACTION_LEN-1:0]          action,
    output logic [DATA_WIDTH-1:0]          op1,
    output logic [DATA_WIDTH-1:0]          op2,
    output logic [DATA_WIDTH-1:0]          op3,
    output logic                           noop
);

    localparam int unsigned IW = $clog2(NUM_CONT);

    logic [3:0]            op;
    logic [4:0]            idx1;
    logic [4:0]            idx2;
    logic [15:0]           imm;
    logic [4:0]            addr;
    logic [DATA_WIDTH-1:0] cont [NUM_CONT];
    logic [DATA_WIDTH-1:0] c1;
    logic [DATA_WIDTH-1:0] c2;
    logic                  bad1;
    logic                  bad2;

    assign op   = action[OP_MSB:OP_LSB];
    assign idx1 = action[IDX1_MSB:IDX1_LSB];
    assign idx2 = action[IDX2_MSB:IDX2_LSB];
    assign imm  = action[IMM_MSB:IMM_LSB];
    assign addr = action[ADDR_MSB:ADDR_LSB];

    always_comb begin
        for (int i = 0; i < int'(NUM_CONT); i++) begin
            cont[i] = phv[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Out-of-range indices alias into the array here, but they also force noop.
    assign c1   = cont[idx1[IW-1:0]];
    assign c2   = cont[idx2[IW-1:0]];
    assign bad1 = 32'(idx1) >= NUM_CONT;
    assign bad2 = 32'(idx2) >= NUM_CONT;

    always_comb begin
        op1  = '0;
        op2  = '0;
        op3  = c1;
        noop = bad1;
        case (op)
            OP_ADD, OP_SUB: begin
                op1  = c1;
                op2  = c2;
                noop = bad1 | bad2;
            end
            OP_ADDI, OP_SUBI: begin
                op1 = c1;
                op2 = DATA_WIDTH'(imm);
            end
            OP_STORE: begin
                op1 = c1;
                op2 = DATA_WIDTH'(addr);
            end
            OP_LOAD: begin
                op2 = DATA_WIDTH'(addr);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu2_action_issuer.sv
// Type-2 ALU action initiator: latch PHV + action, issue once, await the result,
// write it back and hand the PHV downstream. Define ALU2_ISSUER_STATS_EN for counters.
module alu2_action_issuer
    import rmt_action_pkg::*;
#(
    parameter int unsigned NUM_CONT    = 8,
    parameter int unsigned ACTION_LEN  = 25,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
    input  logic [ACTION_LEN-1:0]          action_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [ACTION_LEN-1:0]          alu_action,
    output logic                           alu_action_valid,
    output logic [DATA_WIDTH-1:0]          alu_op1,
    output logic [DATA_WIDTH-1:0]          alu_op2,
    output logic [DATA_WIDTH-1:0]          alu_op3,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    input  logic                           alu_result_valid,
    output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
    output logic                           phv_out_valid,
    input  logic                           phv_out_ready,
    output logic                           timeout_err
`ifdef ALU2_ISSUER_STATS_EN
    ,
    output logic [31:0]                    stat_issued,
    output logic [15:0]                    stat_timeouts,
    output logic [15:0]                    stat_noops
`endif
);

    localparam int unsigned PW = NUM_CONT * DATA_WIDTH;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    issuer_state_e         state_q, state_d;
    logic [PW-1:0]         phv_q, phv_d, phv_wb;
    logic [ACTION_LEN-1:0] action_q, action_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    logic [DATA_WIDTH-1:0] sel_op1, sel_op2, sel_op3;
    logic                  sel_noop;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  terr_q, terr_d;
    logic                  timeout_hit;
    logic                  accept_noop;
    logic [4:0]            wb_idx;

    alu2_operand_sel #(
        .NUM_CONT  (NUM_CONT),
        .ACTION_LEN(ACTION_LEN),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_operand_sel (
        .phv   (phv_in),
        .action(action_in),
        .op1   (sel_op1),
        .op2   (sel_op2),
        .op3   (sel_op3),
        .noop  (sel_noop)
    );

    assign wb_idx = action_q[IDX1_MSB:IDX1_LSB];

    always_comb begin
        phv_wb = phv_q;
        for (int i = 0; i < int'(NUM_CONT); i++) begin
            if (i == int'(wb_idx)) begin
                phv_wb[i*DATA_WIDTH +: DATA_WIDTH] = alu_result;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        phv_d       = phv_q;
        action_d    = action_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        op3_d       = op3_q;
        cnt_d       = cnt_q;
        terr_d      = terr_q;
        timeout_hit = 1'b0;
        accept_noop = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    phv_d       = phv_in;
                    action_d    = action_in;
                    op1_d       = sel_op1;
                    op2_d       = sel_op2;
                    op3_d       = sel_op3;
                    accept_noop = sel_noop;
                    state_d     = sel_noop ? StOutput : StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A result arriving on the last allowed cycle beats the timeout.
                if (alu_result_valid) begin
                    if (action_q[OP_MSB:OP_LSB] != OP_STORE) begin
                        phv_d = phv_wb;
                    end
                    state_d = StOutput;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    terr_d      = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = StOutput;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StOutput: begin
                if (phv_out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            phv_q    <= '0;
            action_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            op3_q    <= '0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phv_q    <= phv_d;
            action_q <= action_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            op3_q    <= op3_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
        end
    end

    assign in_ready         = (state_q == StIdle);
    assign alu_action_valid = (state_q == StIssue);
    assign phv_out_valid    = (state_q == StOutput);
    assign alu_action       = action_q;
    assign alu_op1          = op1_q;
    assign alu_op2          = op2_q;
    assign alu_op3          = op3_q;
    assign phv_out          = phv_q;
    assign timeout_err      = terr_q;

`ifdef ALU2_ISSUER_STATS_EN
    logic [31:0] issued_q;
    logic [15:0] timeouts_q;
    logic [15:0] noops_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_q   <= '0;
            timeouts_q <= '0;
            noops_q    <= '0;
        end else begin
            if (state_q == StIssue) issued_q <= issued_q + 32'd1;
            if (timeout_hit) timeouts_q <= timeouts_q + 16'd1;
            if (accept_noop) noops_q <= noops_q + 16'd1;
        end
    end

    assign stat_issued   = issued_q;
    assign stat_timeouts = timeouts_q;
    assign stat_noops    = noops_q;
`endif

endmodule
